// File: rtl/dpsk_pkg.sv
// Shared QPSK phase/Gray mapping and word geometry helpers for the DQPSK symbol depacker.
package dpsk_pkg;

    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;
    localparam logic [1:0] PH_3 = 2'd3;

    // {I,Q} sliced bits to constellation phase index
    function automatic logic [1:0] phase_of(input logic [1:0] iq);
        case (iq)
            2'b11:   phase_of = PH_0;
            2'b01:   phase_of = PH_1;
            2'b00:   phase_of = PH_2;
            default: phase_of = PH_3;
        endcase
    endfunction

    function automatic logic [1:0] gray_of(input logic [1:0] ph);
        case (ph)
            PH_0:    gray_of = 2'b00;
            PH_1:    gray_of = 2'b01;
            PH_2:    gray_of = 2'b11;
            default: gray_of = 2'b10;
        endcase
    endfunction

    function automatic int syms_per_word(input int out_w, input int bps);
        return out_w / bps;
    endfunction

endpackage

// File: rtl/dpsk_symbol_depacker_sync_fifo.sv
// Registered-pointer FIFO with occupancy count; zero-latency head read, a push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o     = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign count_o    = cnt_q;
    assign head_dat_o = mem_q[rd_q];
    assign do_push    = push_i && (!full_o || pop_i);
    assign do_pop     = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/dpsk_symbol_depacker.sv
// Strobe-enabled slicer, differential decoder and MSB-first packer feeding a valid/ready FIFO.
// Decoded symbol 1 edge after the strobe edge, first word valid 3 edges after; full FIFO drops words.
module dpsk_symbol_depacker
    import dpsk_pkg::*;
#(
    parameter int IN_W         = 35,
    parameter int BITS_PER_SYM = 2,
    parameter int OUT_W        = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [IN_W-1:0]        i_in,
    input  logic signed [IN_W-1:0]        q_in,
    input  logic                          sym_stb,
    input  logic                          diff_en,
    output logic [BITS_PER_SYM-1:0]       dec_sym,
    output logic                          dec_valid,
    output logic [OUT_W-1:0]              m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int SPW = syms_per_word(OUT_W, BITS_PER_SYM);
    localparam int CW  = (SPW > 1) ? $clog2(SPW) : 1;
    // BPSK differential reference starts at bit 1, QPSK at phase 0
    localparam logic [1:0] PREV_RST = (BITS_PER_SYM == 1) ? 2'b01 : PH_0;

    logic                    stb_q;
    logic [1:0]              slc_q;
    logic [1:0]              prev_q, prev_d;
    logic [BITS_PER_SYM-1:0] sym_d, dec_sym_q;
    logic                    dec_valid_q;
    logic [OUT_W-1:0]        shreg_q, word_d;
    logic [CW-1:0]           cnt_q;
    logic                    pk_vld_q, push_q;
    logic [OUT_W-1:0]        pk_dat_q, push_dat_q;
    logic                    ovf_q;
    logic                    fifo_full, fifo_empty, pop;
    logic                    unused_bits;

    assign unused_bits = ^{i_in[IN_W-2:0], q_in[IN_W-2:0], slc_q, prev_q};

    always_comb begin
        prev_d = prev_q;
        sym_d  = '0;
        if (BITS_PER_SYM == 2) begin
            prev_d = phase_of(slc_q);
            sym_d  = BITS_PER_SYM'(diff_en ? gray_of(phase_of(slc_q) - prev_q) : slc_q);
        end else begin
            prev_d = {1'b0, slc_q[1]};
            sym_d  = BITS_PER_SYM'(diff_en ? (slc_q[1] ^ prev_q[0]) : slc_q[1]);
        end
        word_d = (shreg_q << BITS_PER_SYM) | OUT_W'(sym_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stb_q       <= 1'b0;
            slc_q       <= '0;
            prev_q      <= PREV_RST;
            dec_sym_q   <= '0;
            dec_valid_q <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            pk_vld_q    <= 1'b0;
            pk_dat_q    <= '0;
            push_q      <= 1'b0;
            push_dat_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            stb_q <= sym_stb;
            if (sym_stb) begin
                slc_q <= {~i_in[IN_W-1], ~q_in[IN_W-1]};
            end
            dec_valid_q <= stb_q;
            pk_vld_q    <= 1'b0;
            if (stb_q) begin
                prev_q    <= prev_d;
                dec_sym_q <= sym_d;
                shreg_q   <= word_d;
                if (cnt_q == CW'(SPW - 1)) begin
                    cnt_q    <= '0;
                    pk_vld_q <= 1'b1;
                    pk_dat_q <= word_d;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            push_q     <= pk_vld_q;
            push_dat_q <= pk_dat_q;
            if (push_q && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign pop = m_valid && m_ready;

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_q),
        .push_dat_i (push_dat_q),
        .pop_i      (pop),
        .head_dat_o (m_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_level)
    );

    assign m_valid   = !fifo_empty;
    assign dec_sym   = dec_sym_q;
    assign dec_valid = dec_valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_dpsk_symbol_depacker.sv
// Directed bench: a queue-level QPSK model checked every cycle plus literal expectations per scenario.
module tb_dpsk_symbol_depacker;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [34:0] i_in = '0;
    logic signed [34:0] q_in = '0;
    logic               sym_stb = 1'b0;
    logic               diff_en = 1'b0;
    logic               m_ready = 1'b0;

    logic [1:0] q_dec_sym;
    logic       q_dec_valid, q_m_valid, q_overflow;
    logic [7:0] q_m_data;
    logic [3:0] q_level;

    logic [0:0] b_dec_sym;
    logic       b_dec_valid, b_m_valid, b_overflow;
    logic [7:0] b_m_data;
    logic [3:0] b_level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dpsk_symbol_depacker #(.IN_W(35), .BITS_PER_SYM(2), .OUT_W(8), .FIFO_DEPTH(8)) u_q (
        .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .sym_stb(sym_stb), .diff_en(diff_en),
        .dec_sym(q_dec_sym), .dec_valid(q_dec_valid), .m_data(q_m_data), .m_valid(q_m_valid),
        .m_ready(m_ready), .fifo_level(q_level), .overflow(q_overflow)
    );

    dpsk_symbol_depacker #(.IN_W(35), .BITS_PER_SYM(1), .OUT_W(8), .FIFO_DEPTH(8)) u_b (
        .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .sym_stb(sym_stb), .diff_en(diff_en),
        .dec_sym(b_dec_sym), .dec_valid(b_dec_valid), .m_data(b_m_data), .m_valid(b_m_valid),
        .m_ready(m_ready), .fifo_level(b_level), .overflow(b_overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural QPSK model: constellation tables, symbol accumulator and a word queue.
    int  ph_tab[4]   = '{2, 1, 3, 0};   // indexed by {I,Q}
    int  gray_tab[4] = '{0, 1, 3, 2};   // indexed by phase
    int  mq[$];
    int  pend_due[$];
    int  pend_word[$];
    int  prev_ph, acc, nsym, cyc;
    bit  m_ovf, live, pdv, edv;
    int  pds, eds;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete(); pend_due.delete(); pend_word.delete();
            prev_ph = 0; acc = 0; nsym = 0; m_ovf = 0;
            pdv = 0; edv = 0; eds = 0; pds = 0; live = 1;
        end else if (live) begin
            int cur, ph, s, w;
            if (mq.size() > 0 && m_ready) void'(mq.pop_front());
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                void'(pend_due.pop_front());
                w = pend_word.pop_front();
                if (mq.size() < 8) mq.push_back(w);
                else m_ovf = 1;
            end
            edv = pdv;
            if (pdv) eds = pds;
            pdv = 0;
            if (sym_stb) begin
                cur = ((i_in >= 0) ? 2 : 0) + ((q_in >= 0) ? 1 : 0);
                ph  = ph_tab[cur];
                s   = diff_en ? gray_tab[(ph - prev_ph + 4) % 4] : cur;
                prev_ph = ph;
                pdv = 1; pds = s;
                acc = ((acc << 2) | s) & 255;
                nsym++;
                if (nsym == 4) begin
                    pend_due.push_back(cyc + 3);
                    pend_word.push_back(acc);
                    nsym = 0;
                end
            end
        end
        #1;
        if (live) begin
            chk("m_valid", int'(q_m_valid), int'(mq.size() > 0));
            chk("fifo_level", int'(q_level), mq.size());
            chk("overflow", int'(q_overflow), int'(m_ovf));
            chk("dec_valid", int'(q_dec_valid), int'(edv));
            if (edv) chk("dec_sym", int'(q_dec_sym), eds);
            if (mq.size() > 0) chk("m_data", int'(q_m_data), mq[0]);
        end
    end

    int dec_log[$];
    always @(posedge clk) begin
        #2;
        if (!rst && q_dec_valid) dec_log.push_back(int'(q_dec_sym));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobe(input bit ip, input bit qp);
        i_in = ip ? 35'sd1000 : -35'sd1000;
        q_in = qp ? 35'sd1000 : -35'sd1000;
        sym_stb = 1'b1;
        tick();
        sym_stb = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int s = 3; s >= 0; s--) strobe(w[2*s+1], w[2*s]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] words [9] = '{8'h0F, 8'h20, 8'h31, 8'h42, 8'h53, 8'h64, 8'h75, 8'h86, 8'h97};
    bit         bpsk_signs [8] = '{1, 0, 0, 1, 1, 1, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        chk("rst_dec_sym", int'(q_dec_sym), 0);
        chk("rst_dec_valid", int'(q_dec_valid), 0);
        chk("rst_m_valid", int'(q_m_valid), 0);
        chk("rst_level", int'(q_level), 0);
        chk("rst_overflow", int'(q_overflow), 0);
        rst = 1'b0;
        tick();

        // 1: QPSK differential
        diff_en = 1'b1;
        dec_log.delete();
        strobe(1, 1); strobe(0, 1); strobe(0, 0); strobe(1, 0);
        tick();
        chk("t1_mvalid_t1", int'(q_m_valid), 0);
        tick();
        chk("t1_mvalid_t2", int'(q_m_valid), 0);
        tick();
        chk("t1_mvalid_t3", int'(q_m_valid), 1);
        chk("t1_m_data", int'(q_m_data), 8'h15);
        chk("t1_dec_count", dec_log.size(), 4);
        if (dec_log.size() == 4) begin
            chk("t1_dec0", dec_log[0], 0);
            chk("t1_dec1", dec_log[1], 1);
            chk("t1_dec2", dec_log[2], 1);
            chk("t1_dec3", dec_log[3], 1);
        end
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        chk("t1_level_after_pop", int'(q_level), 0);

        // 2: QPSK absolute
        diff_en = 1'b0;
        strobe(1, 1); strobe(0, 0); strobe(1, 0); strobe(0, 1);
        tick(); tick(); tick();
        chk("t2_m_data", int'(q_m_data), 8'hC9);
        chk("t2_level", int'(q_level), 1);
        tick(); tick();
        chk("t2_level_hold", int'(q_level), 1);
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        chk("t2_level_popped", int'(q_level), 0);

        // 3: BPSK differential
        do_reset();
        diff_en = 1'b1;
        for (int k = 0; k < 8; k++) strobe(bpsk_signs[k], 1);
        tick(); tick(); tick();
        chk("t3_b_m_valid", int'(b_m_valid), 1);
        chk("t3_b_m_data", int'(b_m_data), 8'h53);
        chk("t3_b_level", int'(b_level), 1);

        // 4: overflow with consumer stalled
        do_reset();
        diff_en = 1'b0;
        for (int j = 0; j < 9; j++) send_word(words[j]);
        repeat (5) tick();
        chk("t4_level_full", int'(q_level), 8);
        chk("t4_overflow", int'(q_overflow), 1);
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t4_mvalid_drain", int'(q_m_valid), 1);
            chk("t4_word", int'(q_m_data), int'(words[k]));
            tick();
        end
        m_ready = 1'b0;
        chk("t4_empty", int'(q_m_valid), 0);
        chk("t4_overflow_sticky", int'(q_overflow), 1);

        // 5: reset discards a partial word
        do_reset();
        strobe(1, 1); strobe(1, 1);
        do_reset();
        strobe(1, 1); strobe(1, 1); strobe(1, 1); strobe(1, 1);
        repeat (6) tick();
        chk("t5_level", int'(q_level), 1);
        chk("t5_m_data", int'(q_m_data), 8'hFF);
        chk("t5_overflow", int'(q_overflow), 0);

        // 6: push into a full FIFO with a simultaneous pop
        do_reset();
        for (int j = 0; j < 8; j++) send_word(words[j]);
        send_word(words[8]);
        tick(); tick();
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        chk("t6_level", int'(q_level), 8);
        chk("t6_overflow", int'(q_overflow), 0);
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t6_word", int'(q_m_data), int'(words[k+1]));
            tick();
        end
        m_ready = 1'b0;
        chk("t6_empty", int'(q_m_valid), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
